cpu_control: RTL and testbench
==============================

Name: cpu_control

Overview:
- Fetch/decode/execute sequencer for the 8-bit CPU. It sits directly upstream of the A/B/OUT register file.
- Reads 8-bit instructions from an external synchronous program ROM.
- Computes the register-file write data (C_in) with a small internal ALU, using A_reg/B_reg fed back from the register file.
- Drives the one-hot write strobes write_a/write_b/write_o and keeps the PC, zero flag and carry flag.

Parameters:
DATA_W, 8, datapath width of C_in, A_reg and B_reg.
ADDR_W, 4, PC/ROM address width. Also the width of the instruction operand field (instr_in[ADDR_W-1:0]).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin execution from PC=0; sampled only in IDLE.
instr_in  input  8  ROM data; [7:4] opcode, [3:0] operand. Valid one cycle after pc_addr is presented.
A_reg  input  DATA_W  current A register value.
B_reg  input  DATA_W  current B register value.
pc_addr  output  ADDR_W  ROM address (the PC).
write_a  output  1  write strobe for register A.
write_b  output  1  write strobe for register B.
write_o  output  1  write strobe for register OUT.
C_in  output  DATA_W  write data for the register file.
zero_flag  output  1  registered; result of last ADD/SUB was zero.
carry_flag  output  1  registered; carry (ADD) or borrow (SUB) of last ADD/SUB.
busy  output  1  high in FETCH, DECODE and EXEC.
halted  output  1  high in HALT.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, PC=0, IR=0, zero_flag=0, carry_flag=0.
  - write_a/b/o=0, C_in=0, busy=0, halted=0.
  - Asserting rst mid-instruction kills any strobe in the same cycle; no partial write.
- States:
  - IDLE: start=1 -> FETCH; otherwise stay.
  - FETCH: pc_addr=PC is presented -> DECODE.
  - DECODE: IR<=instr_in -> EXEC.
  - EXEC: strobes/C_in driven from IR; PC update -> FETCH, or HALT for HLT.
  - HALT: absorbing; left only by rst. start is ignored in every state except IDLE.
- Timing:
  - Exactly 3 cycles per instruction.
  - Strobes are combinational from state==EXEC and IR; each is high for exactly one cycle; at most one is high.
  - Outside EXEC, C_in=0 and all strobes are 0.
- Opcodes (imm = operand zero-extended to DATA_W):
  - 0 NOP: no strobe.
  - 1 LDA: C_in=imm, write_a.
  - 2 LDB: C_in=imm, write_b.
  - 3 ADD: C_in=A_reg+B_reg mod 2^DATA_W, write_a.
  - 4 SUB: C_in=A_reg-B_reg mod 2^DATA_W, write_a.
  - 5 OUT: C_in=A_reg, write_o.
  - 6 JMP: PC<=operand.
  - 7 JZ: PC<=operand if zero_flag, else PC+1.
  - 8 JC: PC<=operand if carry_flag, else PC+1.
  - F HLT: no strobe, PC unchanged, -> HALT.
  - 9-E: treated as NOP.
- Flags:
  - Updated at the end of EXEC of ADD/SUB only; all other opcodes hold them.
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: carry = 1 when A_reg<B_reg (borrow).
  - zero = (C_in==0).
  - JZ/JC read the flag values registered before the current EXEC.
- PC:
  - Non-jump, non-HLT opcodes: PC<=PC+1 at the end of EXEC, wrapping 2^ADDR_W-1 -> 0.
  - A jump to the current address is legal and loops.

Test Plan:
- ROM {0x15, 0x23, 0x30, 0x50, 0xF0} (LDA 5, LDB 3, ADD, OUT, HLT), start pulse:
  - write_a with C_in=0x05 in the 3rd cycle after start.
  - write_b C_in=0x03, write_a C_in=0x08, write_o C_in=0x08, each 3 cycles apart.
  - Then halted=1, busy=0, pc_addr=4 held; zero=0, carry=0.
- ROM {0x13, 0x25, 0x40, 0x89, ...; addr 9 = 0x5F}:
  - SUB gives C_in=0xFE, carry_flag=1, zero_flag=0.
  - JC is taken; next fetch pc_addr=9, then write_o.
- ROM {0x14, 0x24, 0x40, 0x7C, ...}:
  - SUB gives C_in=0x00, zero_flag=1.
  - JZ is taken; pc_addr=12 on the next FETCH.
- All-NOP ROM:
  - pc_addr counts 0..15 then 0 with period 3 cycles.
  - No strobe ever asserts; start pulses while busy are ignored.
- Reset in the EXEC cycle of LDA 0x7:
  - write_a drops in the same cycle and A is not written.
  - After release: state IDLE, pc_addr=0, flags 0; a new start runs from address 0.
- Opcode 0xA followed by HLT:
  - No strobe for 0xA; PC advances by 1; then halted.

Source files
------------

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - fetch/decode/execute sequencer for the 8-bit CPU
//
// Purpose: steps FETCH -> DECODE -> EXEC once per instruction (3 cycles),
// reading instructions from a synchronous program ROM. It produces register
// file write data with a small ALU and keeps the PC, zero flag and carry flag.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin execution from PC=0 (only honoured in IDLE)
//   instr_in          ROM data, [7:4] opcode, [ADDR_W-1:0] operand
//   A_reg, B_reg      current register file A/B values
//   pc_addr           ROM address (the PC)
//   write_a/b/o       one-hot register file write strobes (EXEC only)
//   C_in              register file write data (0 outside EXEC)
//   zero_flag         result of last ADD/SUB was zero
//   carry_flag        carry (ADD) or borrow (SUB) of last ADD/SUB
//   busy, halted      status: busy in FETCH/DECODE/EXEC, halted in HALT
module cpu_control #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        instr_in,
  input  logic [DATA_W-1:0] A_reg,
  input  logic [DATA_W-1:0] B_reg,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              write_a,
  output logic              write_b,
  output logic              write_o,
  output logic [DATA_W-1:0] C_in,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [7:0]        ir;
  logic              zero_nxt, carry_nxt;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign opcode  = ir[7:4];
  assign operand = ir[ADDR_W-1:0];
  assign imm     = {{(DATA_W-ADDR_W){1'b0}}, operand};

  // One extra bit on each operand: the top bit of the sum is the carry, and
  // the top bit of the difference is the borrow (set exactly when A < B).
  assign sum  = {1'b0, A_reg} + {1'b0, B_reg};
  assign diff = {1'b0, A_reg} - {1'b0, B_reg};

  assign pc_addr = pc;
  assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      zero_flag  <= zero_nxt;
      carry_flag <= carry_nxt;
      // ROM data for the address presented in FETCH is valid during DECODE.
      if (state == S_DECODE) begin
        ir <= instr_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    zero_nxt  = zero_flag;
    carry_nxt = carry_flag;
    write_a   = 1'b0;
    write_b   = 1'b0;
    write_o   = 1'b0;
    C_in      = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + ADDR_W'(1);
        case (opcode)
          OP_NOP: ;
          OP_LDA: begin
            C_in    = imm;
            write_a = 1'b1;
          end
          OP_LDB: begin
            C_in    = imm;
            write_b = 1'b1;
          end
          OP_ADD: begin
            C_in      = sum[DATA_W-1:0];
            write_a   = 1'b1;
            carry_nxt = sum[DATA_W];
            zero_nxt  = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            C_in      = diff[DATA_W-1:0];
            write_a   = 1'b1;
            carry_nxt = diff[DATA_W];
            zero_nxt  = (diff[DATA_W-1:0] == '0);
          end
          OP_OUT: begin
            C_in    = A_reg;
            write_o = 1'b1;
          end
          OP_JMP: pc_nxt = operand;
          // Conditional jumps test the flags as they stood before this EXEC.
          OP_JZ: begin
            if (zero_flag) begin
              pc_nxt = operand;
            end
          end
          OP_JC: begin
            if (carry_flag) begin
              pc_nxt = operand;
            end
          end
          OP_HLT: begin
            state_nxt = S_HALT;
            pc_nxt    = pc;
          end
          default: ;
        endcase
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - scoreboard testbench for cpu_control
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] instr_in = 8'h00;
  logic [7:0] a_q = 8'h00;
  logic [7:0] b_q = 8'h00;
  logic [7:0] o_q = 8'h00;
  logic [3:0] pc_addr;
  logic       write_a, write_b, write_o;
  logic [7:0] C_in;
  logic       zero_flag, carry_flag, busy, halted;

  logic [7:0] rom [16];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         t0;

  typedef struct {
    logic [2:0] strb;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [2:0] SA = 3'b100;
  localparam logic [2:0] SB = 3'b010;
  localparam logic [2:0] SO = 3'b001;

  cpu_control #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .instr_in(instr_in),
    .A_reg(a_q),
    .B_reg(b_q),
    .pc_addr(pc_addr),
    .write_a(write_a),
    .write_b(write_b),
    .write_o(write_o),
    .C_in(C_in),
    .zero_flag(zero_flag),
    .carry_flag(carry_flag),
    .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    instr_in <= rom[pc_addr];
    if (write_a) a_q <= C_in;
    if (write_b) b_q <= C_in;
    if (write_o) o_q <= C_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] strb, input logic [7:0] data, input int at);
    sb.push_back('{strb, data, at});
  endtask

  // Every strobe seen must match the head of the scoreboard: which strobe,
  // data and cycle.
  always @(negedge clk) begin
    if (!rst && (write_a || write_b || write_o)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, write_a, write_b, write_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe", {29'd0, write_a, write_b, write_o}, {29'd0, mon_e.strb});
        check("c_in", {24'd0, C_in}, {24'd0, mon_e.data});
        check("strobe_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_start(output int t);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic sb_done(input string tag);
    check(tag, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fill(8'h00);

    // Reset state
    @(negedge clk);
    check("rst_pc", {28'd0, pc_addr}, 32'd0);
    check("rst_strobes", {29'd0, write_a, write_b, write_o}, 32'd0);
    check("rst_c_in", {24'd0, C_in}, 32'd0);
    check("rst_status", {28'd0, busy, halted, zero_flag, carry_flag}, 32'd0);

    // LDA 5, LDB 3, ADD, OUT, HLT
    fill(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h30; rom[3] = 8'h50; rom[4] = 8'hF0;
    do_reset();
    run_start(t0);
    push(SA, 8'h05, t0 + 2);
    push(SB, 8'h03, t0 + 5);
    push(SA, 8'h08, t0 + 8);
    push(SO, 8'h08, t0 + 11);
    wait_neg(t0 + 16);
    check("p1_halted", {30'd0, halted, busy}, 32'd2);
    check("p1_pc", {28'd0, pc_addr}, 32'd4);
    check("p1_flags", {30'd0, zero_flag, carry_flag}, 32'd0);
    start = 1'b1;
    wait_neg(t0 + 22);
    start = 1'b0;
    check("p1_hold", {27'd0, halted, busy, pc_addr}, {27'd0, 1'b1, 1'b0, 4'd4});
    check("p1_out_reg", {24'd0, o_q}, 32'h08);
    sb_done("p1_sb_empty");

    // SUB with borrow, JC taken to address 9 (OUT)
    fill(8'hF0);
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h40; rom[3] = 8'h89; rom[9] = 8'h5F;
    do_reset();
    run_start(t0);
    push(SA, 8'h03, t0 + 2);
    push(SB, 8'h05, t0 + 5);
    push(SA, 8'hFE, t0 + 8);
    push(SO, 8'hFE, t0 + 14);
    wait_neg(t0 + 9);
    check("p2_carry", {31'd0, carry_flag}, 32'd1);
    check("p2_zero", {31'd0, zero_flag}, 32'd0);
    wait_neg(t0 + 12);
    check("p2_jc_pc", {28'd0, pc_addr}, 32'd9);
    wait_neg(t0 + 19);
    check("p2_halted", {31'd0, halted}, 32'd1);
    sb_done("p2_sb_empty");

    // SUB to zero, JZ taken to address 12
    fill(8'hF0);
    rom[0] = 8'h14; rom[1] = 8'h24; rom[2] = 8'h40; rom[3] = 8'h7C; rom[12] = 8'h50;
    do_reset();
    run_start(t0);
    push(SA, 8'h04, t0 + 2);
    push(SB, 8'h04, t0 + 5);
    push(SA, 8'h00, t0 + 8);
    push(SO, 8'h00, t0 + 14);
    wait_neg(t0 + 9);
    check("p3_flags", {30'd0, zero_flag, carry_flag}, 32'd2);
    wait_neg(t0 + 12);
    check("p3_jz_pc", {28'd0, pc_addr}, 32'd12);
    wait_neg(t0 + 19);
    check("p3_halted", {31'd0, halted}, 32'd1);
    sb_done("p3_sb_empty");

    // All-NOP ROM: PC wraps, start while busy ignored, no strobes
    fill(8'h00);
    do_reset();
    run_start(t0);
    for (int k = 0; k < 18; k++) begin
      wait_neg(t0 + 3 * k);
      check("nop_pc", {28'd0, pc_addr}, k % 16);
      check("nop_busy", {30'd0, busy, halted}, 32'd2);
      if (k == 4) start = 1'b1;
      if (k == 7) start = 1'b0;
    end
    sb_done("nop_sb_empty");

    // Reset during EXEC of LDA 7
    fill(8'hF0);
    rom[0] = 8'h13; rom[1] = 8'h17;
    do_reset();
    run_start(t0);
    push(SA, 8'h03, t0 + 2);
    wait_neg(t0 + 4);
    @(posedge clk);
    #1;
    check("rstx_pre_strobe", {31'd0, write_a}, 32'd1);
    check("rstx_pre_c_in", {24'd0, C_in}, 32'h07);
    rst = 1'b1;
    #1;
    check("rstx_strobe_killed", {29'd0, write_a, write_b, write_o}, 32'd0);
    check("rstx_c_in", {24'd0, C_in}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstx_a_kept", {24'd0, a_q}, 32'h03);
    check("rstx_state", {27'd0, busy, halted, zero_flag, carry_flag, 1'b0}, 32'd0);
    check("rstx_pc", {28'd0, pc_addr}, 32'd0);
    sb_done("rstx_sb_empty");
    run_start(t0);
    push(SA, 8'h03, t0 + 2);
    push(SA, 8'h07, t0 + 5);
    wait_neg(t0 + 10);
    check("rstx_rerun_halted", {31'd0, halted}, 32'd1);
    check("rstx_rerun_a", {24'd0, a_q}, 32'h07);
    sb_done("rstx_rerun_sb_empty");

    // Unused opcode 0xA then HLT
    fill(8'hF0);
    rom[0] = 8'hA0;
    do_reset();
    run_start(t0);
    wait_neg(t0 + 3);
    check("opA_pc", {28'd0, pc_addr}, 32'd1);
    wait_neg(t0 + 7);
    check("opA_halted", {31'd0, halted}, 32'd1);
    check("opA_pc_held", {28'd0, pc_addr}, 32'd1);
    sb_done("opA_sb_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
